fetch_unit: RTL and testbench

Instruction fetch front end that produces the OPCODE and instruction fields consumed by the main control decoder and register file. It holds the PC and issues word reads to instruction memory over a req/ack handshake. It latches the returned word into an instruction register and presents it to the datapath with a valid/ready handshake. On consumption it advances the PC sequentially, or to the branch target when the datapath reports a taken beq.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/pc_next.sv | 15 +
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding and next-PC arithmetic.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    StRst   = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

  // Branch offset: IMM sign-extended to 30 bits, then shifted left 2; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic [15:0] imm,
                                          input logic        taken);
    logic [31:0] seq;
    logic [31:0] off;
    seq = pc + 32'd4;
    off = {{14{imm[15]}}, imm, 2'b00};
    return taken ? seq + off : seq;
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC adder/mux, reusable by the datapath.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic        taken,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc
);

  assign pc_plus4 = pc + 32'd4;
  assign npc      = next_pc(pc, imm, taken);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem req/ack, instruction register and field decode.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             Branch,
  input  logic             Zero,
  output logic [5:0]       OPCODE,
  output logic [4:0]       RS,
  output logic [4:0]       RT,
  output logic [4:0]       RD,
  output logic [4:0]       SHAMT,
  output logic [5:0]       FUNCT,
  output logic [15:0]      IMM,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      npc;
  logic             consume;

  assign consume = (state_q == StHold) && instr_ready;

  pc_next u_pc_next (
    .pc       (pc_q),
    .imm      (ir_q[15:0]),
    .taken    (Branch & Zero),
    .pc_plus4 (pc_plus4),
    .npc      (npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRst;
      pc_q      <= RESET_PC & ~32'h3;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:   state_d = StFetch;
      StFetch: if (imem_ack) state_d = StHold;
      StHold:  if (instr_ready) state_d = StFetch;
      default: state_d = StRst;
    endcase
  end

  // Acks are only meaningful in FETCH; stray acks never touch IR.
  always_comb begin
    ir_d      = ir_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    if ((state_q == StFetch) && imem_ack) ir_d = imem_rdata;
    if (consume) begin
      pc_d      = npc;
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    imem_req    = (state_q == StFetch);
    instr_valid = (state_q == StHold);
  end

  assign imem_addr = pc_q;
  assign retired   = retired_q;
  assign OPCODE    = ir_q[31:26];
  assign RS        = ir_q[25:21];
  assign RT        = ir_q[20:16];
  assign RD        = ir_q[15:11];
  assign SHAMT     = ir_q[10:6];
  assign FUNCT     = ir_q[5:0];
  assign IMM       = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a PC/retire-count reference model.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        Branch;
  logic        Zero;
  logic [5:0]  OPCODE;
  logic [4:0]  RS, RT, RD, SHAMT;
  logic [5:0]  FUNCT;
  logic [15:0] IMM;
  logic [31:0] pc_plus4;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC and retire count.
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .Branch      (Branch),
    .Zero        (Zero),
    .OPCODE      (OPCODE),
    .RS          (RS),
    .RT          (RT),
    .RD          (RD),
    .SHAMT       (SHAMT),
    .FUNCT       (FUNCT),
    .IMM         (IMM),
    .pc_plus4    (pc_plus4),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction: wait ack_dly cycles, ack with word, stall rdy_dly cycles, then consume.
  task automatic fetch_one(input logic [31:0] word, input int ack_dly, input int rdy_dly,
                           input logic br, input logic z);
    int off;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      Branch      = 1'($urandom_range(0, 1));
      Zero        = 1'($urandom_range(0, 1));
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        n_fail++;
        $display("FAIL fetch_wait: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr,
                 exp_pc);
      end
      tick();
    end
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = word;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL fetch_ack: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, exp_pc);
    end
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    n_tests++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
        {OPCODE, RS, RT, RD, SHAMT, FUNCT} !== word || IMM !== word[15:0] ||
        pc_plus4 !== exp_pc + 32'd4) begin
      n_fail++;
      $display("FAIL hold_fields: valid=%b req=%b ir=%h imm=%h pc4=%h, want 1 0 %h %h %h",
               instr_valid, imem_req, {OPCODE, RS, RT, RD, SHAMT, FUNCT}, IMM, pc_plus4,
               word, word[15:0], exp_pc + 32'd4);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      Branch     = 1'($urandom_range(0, 1));
      Zero       = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (instr_valid !== 1'b1 || {OPCODE, RS, RT, RD, SHAMT, FUNCT} !== word) begin
        n_fail++;
        $display("FAIL hold_stall: valid=%b ir=%h, want 1 %h", instr_valid,
                 {OPCODE, RS, RT, RD, SHAMT, FUNCT}, word);
      end
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    Branch      = br;
    Zero        = z;
    tick();
    instr_ready = 1'b0;
    Branch      = 1'($urandom_range(0, 1));
    Zero        = 1'($urandom_range(0, 1));
    off         = int'($signed(word[15:0]));
    exp_pc      = exp_pc + 32'd4 + ((br && z) ? 32'(off * 4) : 32'd0);
    exp_ret     = exp_ret + 32'd1;
    n_tests++;
    if (retired !== exp_ret || instr_valid !== 1'b0 || imem_req !== 1'b1 ||
        imem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL consume: retired=%0d valid=%b req=%b addr=%h, want %0d 0 1 %h", retired,
               instr_valid, imem_req, imem_addr, exp_ret, exp_pc);
    end
  endtask

  // Taken beq whose target is the requested address.
  task automatic steer(input logic [31:0] target);
    logic [31:0] d;
    d = target - exp_pc - 32'd4;
    fetch_one({OP_BEQ, 5'd1, 5'd2, d[17:2]}, $urandom_range(0, 2), $urandom_range(0, 2),
              1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    instr_ready = 1'b1;
    Branch      = 1'b0;
    Zero        = 1'b0;
    tick();
    tick();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || retired !== 32'd0 ||
        {OPCODE, RS, RT, RD, SHAMT, FUNCT} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b valid=%b retired=%0d ir=%h, want 0 0 0 0", imem_req,
               instr_valid, retired, {OPCODE, RS, RT, RD, SHAMT, FUNCT});
    end
    rst = 1'b0;
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle1: req=%b, want 0", imem_req);
    end
    tick();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL first_fetch: req=%b addr=%h, want 1 00000040", imem_req, imem_addr);
    end
    exp_pc  = RST_PC;
    exp_ret = 32'd0;
  endtask

  task automatic test_stall();
    fetch_one(32'h8C22_0004, 5, 3, 1'b0, 1'b1);
    n_tests++;
    if (retired !== 32'd1 || imem_addr !== 32'h0000_0044) begin
      n_fail++;
      $display("FAIL stall_result: retired=%0d addr=%h, want 1 00000044", retired, imem_addr);
    end
  endtask

  task automatic test_branch();
    steer(32'h0000_0100);
    fetch_one({OP_BEQ, 5'd3, 5'd3, 16'hFFFE}, 1, 0, 1'b1, 1'b1);
    n_tests++;
    if (imem_addr !== 32'h0000_00FC) begin
      n_fail++;
      $display("FAIL beq_taken: addr=%h, want 000000fc", imem_addr);
    end
    steer(32'h0000_0100);
    fetch_one({OP_BEQ, 5'd3, 5'd4, 16'hFFFE}, 0, 1, 1'b1, 1'b0);
    n_tests++;
    if (imem_addr !== 32'h0000_0104) begin
      n_fail++;
      $display("FAIL beq_not_taken: addr=%h, want 00000104", imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [25:0] rest;
    steer(32'hFFFF_FFFC);
    rest = 26'($urandom);
    fetch_one({OP_RTYPE, rest}, 0, 0, 1'b0, 1'($urandom_range(0, 1)));
    n_tests++;
    if (imem_addr !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL pc_wrap: addr=%h, want 00000000", imem_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_fetch();
    steer(32'h0000_0200);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C22_0004;
    tick();
    rst = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || retired !== 32'd0 ||
        {OPCODE, RS, RT, RD, SHAMT, FUNCT} !== 32'd0) begin
      n_fail++;
      $display("FAIL midfetch_reset: valid=%b req=%b retired=%0d ir=%h, want 0 0 0 0",
               instr_valid, imem_req, retired, {OPCODE, RS, RT, RD, SHAMT, FUNCT});
    end
    tick();
    imem_ack = 1'b0;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0040 || instr_valid !== 1'b0 ||
        {OPCODE, RS, RT, RD, SHAMT, FUNCT} !== 32'd0) begin
      n_fail++;
      $display("FAIL refetch: req=%b addr=%h valid=%b ir=%h, want 1 00000040 0 0", imem_req,
               imem_addr, instr_valid, {OPCODE, RS, RT, RD, SHAMT, FUNCT});
    end
    exp_pc  = RST_PC;
    exp_ret = 32'd0;
  endtask

  task automatic test_back_to_back();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    Branch      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_rdata = $urandom;
      Zero       = 1'($urandom_range(0, 1));
      tick();
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    exp_pc      = exp_pc + 32'd40;
    exp_ret     = exp_ret + 32'd10;
    n_tests++;
    if (retired !== 32'd10 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL throughput: retired=%0d req=%b addr=%h, want 10 1 %h", retired, imem_req,
               imem_addr, exp_pc);
    end
  endtask

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    Branch      = 1'b0;
    Zero        = 1'b0;
    exp_pc      = RST_PC;
    exp_ret     = '0;
    test_reset();
    test_stall();
    test_branch();
    test_wrap();
    test_random();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
